time_set_ctrl: RTL and testbench
================================

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 4, meaning the number of consecutive stable clocks needed to accept a debounced level change.
REQ-002 The block SHALL have parameter RPT_DELAY, default 32, meaning clocks from the first pulse to the first auto-repeat pulse.
REQ-003 The block SHALL have parameter RPT_PERIOD, default 8, meaning clocks between subsequent auto-repeat pulses.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning idle clocks in a set mode before returning to RUN.
REQ-005 The block SHALL have port clk, input, 1 bit: system clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-007 The block SHALL have ports btn_mode, btn_up and btn_down, each input, 1 bit: raw asynchronous push-button levels, high = pressed.
REQ-008 The block SHALL have ports min_inc, min_dec, hour_inc and hour_dec, each output, 1 bit: single-cycle registered adjust pulses to the timekeeping counter.
REQ-009 The block SHALL have port set_mode, output, 2 bits: 00 = RUN, 01 = SET_HOUR, 10 = SET_MIN; 11 never driven.
REQ-010 The block SHALL have port clock_hold, output, 1 bit: high whenever set_mode is not RUN, to freeze seconds counting.

Function
REQ-011 Each button SHALL pass through a two-flop synchronizer, then a debouncer whose level changes only after the synchronized input differs from it for DB_CYCLES consecutive clocks.
REQ-012 A press event SHALL be a one-clock strobe on a debounced 0->1 transition.
REQ-013 FSM transitions SHALL be: RUN -mode press-> SET_HOUR -mode press-> SET_MIN -mode press-> RUN.
REQ-014 In SET_HOUR, an up press SHALL pulse hour_inc and a down press SHALL pulse hour_dec; in SET_MIN, they SHALL pulse min_inc and min_dec respectively.
REQ-015 In RUN, up and down presses SHALL be ignored and no adjust pulse SHALL be produced.
REQ-016 Each adjust pulse SHALL be high for exactly one clock, and at most one of the four pulses SHALL be high in any cycle.
REQ-017 Latency SHALL be exactly DB_CYCLES+3 rising edges from the first edge sampling a clean raw press to the edge at which the output pulse is registered high.
REQ-018 A mode press coinciding with an up or down press SHALL take priority: the state advances and no adjust pulse is produced.
REQ-019 While debounced up and down are both high, no adjust pulse SHALL be produced and the repeat counter SHALL be held at zero.
REQ-020 The idle counter SHALL clear on any press and on every state change, and in a set mode SHALL force the state to RUN upon reaching TIMEOUT_CYCLES.
REQ-021 The idle counter SHALL be held at zero while in RUN.
REQ-022 A mode transition SHALL clear any repeat in progress.

Reset
REQ-023 While reset is high, set_mode SHALL be 00, clock_hold SHALL be 0, all four adjust pulses SHALL be 0, and all debounce, repeat and idle counters SHALL be 0.
REQ-024 A button held high through reset deassertion SHALL produce no press event until its debounced level has been observed low at least once.
REQ-025 Reset asserted mid-repeat or mid-set SHALL abort the operation with no further pulses.

Configuration
REQ-026 With TIME_SET_AUTO_REPEAT_EN defined, a held up or down button SHALL produce a further pulse RPT_DELAY clocks after the initial pulse, then one every RPT_PERIOD clocks until release.
REQ-027 With TIME_SET_AUTO_REPEAT_EN undefined, exactly one pulse SHALL be produced per press regardless of hold time, and the repeat counter SHALL be absent.

Verification
REQ-028 Reset with btn_mode held high, release reset, hold 100 clocks -> set_mode stays 00; release, then press -> set_mode becomes 01 and clock_hold becomes 1.
REQ-029 In SET_HOUR, with DB_CYCLES=4, drive a clean 20-clock btn_up press -> hour_inc high for exactly 1 clock, 7 edges after press start; no other pulse.
REQ-030 In SET_MIN, toggle btn_down for 3-clock glitches 10 times -> no min_dec pulse.
REQ-031 With TIME_SET_AUTO_REPEAT_EN defined, hold btn_up 60 clocks past the first pulse in SET_MIN -> min_inc pulses at offsets 0, 32, 40, 48 and 56.
REQ-032 Enter SET_HOUR and idle for 1024 clocks -> set_mode returns to 00 and clock_hold goes to 0; with a press at clock 1000 -> stays 01 until 1024 clocks after that press.
REQ-033 Press mode and up in the same cycle in SET_HOUR -> set_mode goes to 10 and no hour_inc pulse is produced.

Source files
------------

// File: rtl/time_set_ctrl.sv
// Push-button time-set controller: debounced mode/up/down buttons drive a RUN/SET_HOUR/SET_MIN
// FSM that emits one-clock adjust pulses. Define TIME_SET_AUTO_REPEAT_EN to enable held-button auto-repeat.
module time_set_ctrl #(
    parameter int DB_CYCLES      = 4,
    parameter int RPT_DELAY      = 32,
    parameter int RPT_PERIOD     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       min_inc,
    output logic       min_dec,
    output logic       hour_inc,
    output logic       hour_dec,
    output logic [1:0] set_mode,
    output logic       clock_hold
);
    localparam logic [1:0] ST_RUN  = 2'b00;
    localparam logic [1:0] ST_HOUR = 2'b01;
    localparam logic [1:0] ST_MIN  = 2'b10;

    localparam int B_MODE = 0;
    localparam int B_UP   = 1;
    localparam int B_DN   = 2;

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

    logic [2:0]    w_btn;
    logic [2:0]    r_sync1, r_sync2, r_db, r_db_q;
    logic [CW-1:0] r_db_cnt [3];
    logic [2:0]    w_press;
    logic [1:0]    r_state, w_state_nxt;
    logic [IW-1:0] r_idle;
    logic          w_both, w_timeout, w_rpt_fire, w_adj_en, w_do_up, w_do_dn;
    logic          r_min_inc, r_min_dec, r_hour_inc, r_hour_dec;

    assign w_btn = {btn_down, btn_up, btn_mode};

    // Debounced levels and their history reset high: a button held through reset
    // must be seen released before it can generate a rising-edge press.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '1;
            r_db_q  <= '1;
            for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            r_db_q  <= r_db;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db[i]     <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_press   = r_db & ~r_db_q;
    assign w_both    = r_db[B_UP] & r_db[B_DN];
    assign w_timeout = (r_state != ST_RUN) && (r_idle == IDLE_LAST) && (w_press == 3'b000);
    assign w_adj_en  = (r_state != ST_RUN) && !w_press[B_MODE] && !w_timeout && !w_both;
    assign w_do_up   = w_adj_en && (w_press[B_UP] || (w_rpt_fire && r_db[B_UP]));
    assign w_do_dn   = w_adj_en && (w_press[B_DN] || (w_rpt_fire && r_db[B_DN]));

    always_comb begin
        w_state_nxt = ST_RUN;
        case (r_state)
            ST_RUN:  w_state_nxt = ST_HOUR;
            ST_HOUR: w_state_nxt = ST_MIN;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_idle     <= '0;
            r_min_inc  <= 1'b0;
            r_min_dec  <= 1'b0;
            r_hour_inc <= 1'b0;
            r_hour_dec <= 1'b0;
        end else begin
            if (w_press[B_MODE]) begin
                r_state <= w_state_nxt;
                r_idle  <= '0;
            end else if (w_timeout) begin
                r_state <= ST_RUN;
                r_idle  <= '0;
            end else if (r_state == ST_RUN || w_press != 3'b000) begin
                r_idle <= '0;
            end else begin
                r_idle <= r_idle + 1'b1;
            end
            r_hour_inc <= w_do_up && (r_state == ST_HOUR);
            r_hour_dec <= w_do_dn && (r_state == ST_HOUR);
            r_min_inc  <= w_do_up && (r_state == ST_MIN);
            r_min_dec  <= w_do_dn && (r_state == ST_MIN);
        end
    end

`ifdef TIME_SET_AUTO_REPEAT_EN
    localparam int RW = $clog2(RPT_DELAY + 1);
    localparam logic [RW-1:0] RPT_FIRE   = RW'(RPT_DELAY);
    localparam logic [RW-1:0] RPT_RELOAD = RW'(RPT_DELAY - RPT_PERIOD + 1);

    // r_rpt counts clocks since the last pulse of the held button; zero means idle.
    logic [RW-1:0] r_rpt;
    assign w_rpt_fire = (r_rpt == RPT_FIRE);

    always_ff @(posedge clk) begin
        if (reset || w_press[B_MODE] || w_timeout || r_state == ST_RUN || w_both ||
            !(r_db[B_UP] || r_db[B_DN])) begin
            r_rpt <= '0;
        end else if (w_press[B_UP] || w_press[B_DN]) begin
            r_rpt <= RW'(1);
        end else if (w_rpt_fire) begin
            r_rpt <= RPT_RELOAD;
        end else if (r_rpt != '0) begin
            r_rpt <= r_rpt + 1'b1;
        end
    end
`else
    assign w_rpt_fire = 1'b0;
`endif

    assign min_inc    = r_min_inc;
    assign min_dec    = r_min_dec;
    assign hour_inc   = r_hour_inc;
    assign hour_dec   = r_hour_dec;
    assign set_mode   = r_state;
    assign clock_hold = (r_state != ST_RUN);
endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: expected adjust pulses (cycle + which output) are queued
// as buttons are driven and matched as the DUT emits them.
module tb_time_set_ctrl;
    localparam int DB  = 4;
    localparam int LAT = DB + 3;
    localparam logic [3:0] HOUR_INC = 4'b1000;
    localparam logic [3:0] HOUR_DEC = 4'b0100;
    localparam logic [3:0] MIN_INC  = 4'b0010;
    localparam logic [3:0] MIN_DEC  = 4'b0001;
    localparam int B_MODE = 0, B_UP = 1, B_DN = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic       min_inc, min_dec, hour_inc, hour_dec;
    logic [1:0] set_mode;
    logic       clock_hold;

    typedef struct {
        int         cyc;
        logic [3:0] vec;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    time_set_ctrl #(
        .DB_CYCLES(DB), .RPT_DELAY(32), .RPT_PERIOD(8), .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
        .min_inc(min_inc), .min_dec(min_dec), .hour_inc(hour_inc), .hour_dec(hour_dec),
        .set_mode(set_mode), .clock_hold(clock_hold)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0d exp=%0d (cyc %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int dly, input logic [3:0] v);
        exp_t e;
        e.cyc = cyc + dly;
        e.vec = v;
        sb.push_back(e);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            B_MODE:  btn_mode = v;
            B_UP:    btn_up   = v;
            default: btn_down = v;
        endcase
    endtask

    task automatic tap(input int b, input int hold, input logic [3:0] v);
        set_btn(b, 1'b1);
        if (v != 4'b0000) push_exp(LAT, v);
        wait_clk(hold);
        set_btn(b, 1'b0);
        wait_clk(20);
    endtask

    always @(negedge clk) begin
        logic [3:0] w;
        exp_t       e;
        w = {hour_inc, hour_dec, min_inc, min_dec};
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            chk("missed_pulse", cyc, e.cyc);
        end
        if (w != 4'b0000) begin
            chk("pulse_onehot", $countones(w), 1);
            if (sb.size() == 0) begin
                chk("spurious_pulse", int'(w), 0);
            end else begin
                e = sb.pop_front();
                chk("pulse_vec", int'(w), int'(e.vec));
                chk("pulse_cyc", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with mode held; it must not register as a press afterwards.
        btn_mode = 1'b1;
        wait_clk(5);
        chk("rst_mode", set_mode, 0);
        chk("rst_hold", clock_hold, 0);
        chk("rst_pulses", {hour_inc, hour_dec, min_inc, min_dec}, 0);
        reset = 1'b0;
        wait_clk(100);
        chk("held_mode_ignored", set_mode, 0);
        btn_mode = 1'b0;
        wait_clk(20);
        chk("released_mode_still_run", set_mode, 0);
        tap(B_MODE, 10, 4'b0000);
        chk("enter_hour", set_mode, 1);
        chk("enter_hour_hold", clock_hold, 1);

        // SET_HOUR adjustments.
        tap(B_UP, 20, HOUR_INC);
        tap(B_DN, 20, HOUR_DEC);

        // Mode and up together: mode wins, no pulse.
        btn_mode = 1'b1;
        btn_up   = 1'b1;
        wait_clk(10);
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        wait_clk(20);
        chk("mode_priority", set_mode, 2);

        // Short glitches on down never pass the debouncer.
        for (int i = 0; i < 10; i++) begin
            btn_down = 1'b1;
            wait_clk(3);
            btn_down = 1'b0;
            wait_clk(3);
        end
        wait_clk(20);
        chk("glitch_still_min", set_mode, 2);

        tap(B_DN, 20, MIN_DEC);

        // Long hold of up: auto-repeat offsets when enabled, single pulse otherwise.
        btn_up = 1'b1;
        push_exp(LAT, MIN_INC);
`ifdef TIME_SET_AUTO_REPEAT_EN
        push_exp(LAT + 32, MIN_INC);
        push_exp(LAT + 40, MIN_INC);
        push_exp(LAT + 48, MIN_INC);
        push_exp(LAT + 56, MIN_INC);
`endif
        wait_clk(62);
        btn_up = 1'b0;
        wait_clk(30);

        // Down held while up pressed: the up press and any repeat are suppressed.
        btn_down = 1'b1;
        push_exp(LAT, MIN_DEC);
        wait_clk(15);
        btn_up = 1'b1;
        wait_clk(15);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        wait_clk(40);
        chk("both_still_min", set_mode, 2);

        tap(B_MODE, 10, 4'b0000);
        chk("back_to_run", set_mode, 0);
        chk("run_hold_low", clock_hold, 0);
        tap(B_UP, 10, 4'b0000);
        tap(B_DN, 10, 4'b0000);

        // Idle timeout: mode press registers the state 7 edges after drive.
        btn_mode = 1'b1;
        wait_clk(10);
        btn_mode = 1'b0;
        wait_clk(1015);
        chk("timeout_not_yet", set_mode, 1);
        wait_clk(10);
        chk("timeout_run", set_mode, 0);
        chk("timeout_hold", clock_hold, 0);

        // Press at entry+1000 restarts the idle window.
        btn_mode = 1'b1;
        wait_clk(10);
        btn_mode = 1'b0;
        wait_clk(990);
        btn_up = 1'b1;
        push_exp(LAT, HOUR_INC);
        wait_clk(10);
        btn_up = 1'b0;
        wait_clk(22);
        chk("idle_cleared_1032", set_mode, 1);
        wait_clk(990);
        chk("idle_cleared_2022", set_mode, 1);
        wait_clk(15);
        chk("timeout2_run", set_mode, 0);

        // Reset mid-set while up is held: no further pulses, stays in RUN.
        tap(B_MODE, 10, 4'b0000);
        chk("reenter_hour", set_mode, 1);
        btn_up = 1'b1;
        push_exp(LAT, HOUR_INC);
        wait_clk(20);
        reset = 1'b1;
        wait_clk(3);
        chk("midop_rst_mode", set_mode, 0);
        chk("midop_rst_hold", clock_hold, 0);
        reset = 1'b0;
        wait_clk(50);
        btn_up = 1'b0;
        wait_clk(20);
        chk("after_rst_run", set_mode, 0);

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
